// File: rtl/instr_mem_loader.sv
// Instruction memory loader: accepts 32-bit words over a valid/ready handshake
// and writes each one as four big-endian bytes into a byte-wide memory.
module instr_mem_loader #(
  parameter int MEM_BYTES = 128
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [6:0]  base_adrs,
  input  logic        in_valid,
  input  logic        in_last,
  input  logic [31:0] in_instr,
  output logic        in_ready,
  output logic        wr_en,
  output logic [6:0]  wr_adrs,
  output logic [7:0]  wr_data,
  output logic        busy,
  output logic        done,
  output logic        overflow,
  output logic [5:0]  word_count
);

  typedef enum logic [1:0] {IDLE, ACCEPT, WRITE, DONE} state_t;

  state_t      state, state_d;
  logic [1:0]  k, k_d, k_nxt;
  logic [6:0]  addr, addr_d;
  logic [31:0] word, word_d;
  logic        last, last_d;
  logic        in_ready_d, wr_en_d, busy_d, done_d, overflow_d;
  logic [6:0]  wr_adrs_d;
  logic [7:0]  wr_data_d;
  logic [5:0]  word_count_d;
  logic [7:0]  addr_inc;
  logic        wrap;

  // Big-endian byte pick: byte 0 is the MSB so it lands at the lowest address.
  function automatic logic [7:0] byte_sel(input logic [31:0] w, input logic [1:0] idx);
    case (idx)
      2'd0:    byte_sel = w[31:24];
      2'd1:    byte_sel = w[23:16];
      2'd2:    byte_sel = w[15:8];
      default: byte_sel = w[7:0];
    endcase
  endfunction

  assign k_nxt    = k + 2'd1;
  assign addr_inc = {1'b0, addr} + 8'd4;
  assign wrap     = (int'(addr_inc) >= MEM_BYTES);

  // Next-state and next-output logic; every output is registered, so values
  // computed here appear on the ports one cycle later.
  always_comb begin
    state_d      = state;
    k_d          = k;
    addr_d       = addr;
    word_d       = word;
    last_d       = last;
    in_ready_d   = 1'b0;
    wr_en_d      = 1'b0;
    wr_adrs_d    = wr_adrs;
    wr_data_d    = wr_data;
    busy_d       = busy;
    done_d       = 1'b0;
    overflow_d   = overflow;
    word_count_d = word_count;
    case (state)
      IDLE: begin
        busy_d = 1'b0;
        if (start) begin
          addr_d       = {base_adrs[6:2], 2'b00};
          word_count_d = '0;
          overflow_d   = 1'b0;
          state_d      = ACCEPT;
          in_ready_d   = 1'b1;
          busy_d       = 1'b1;
        end
      end
      ACCEPT: begin
        if (in_valid && in_ready) begin
          word_d    = in_instr;
          last_d    = in_last;
          k_d       = 2'd0;
          state_d   = WRITE;
          wr_en_d   = 1'b1;
          wr_adrs_d = addr;
          wr_data_d = byte_sel(in_instr, 2'd0);
        end else begin
          in_ready_d = 1'b1;
        end
      end
      WRITE: begin
        if (k != 2'd3) begin
          k_d       = k_nxt;
          wr_en_d   = 1'b1;
          wr_adrs_d = addr | {5'b0, k_nxt};
          wr_data_d = byte_sel(word, k_nxt);
        end else begin
          addr_d       = wrap ? 7'd0 : addr_inc[6:0];
          word_count_d = word_count + 6'd1;
          if (wrap) overflow_d = 1'b1;
          if (last || wrap) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            state_d    = ACCEPT;
            in_ready_d = 1'b1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  // Control state and port registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      in_ready   <= 1'b0;
      wr_en      <= 1'b0;
      wr_adrs    <= '0;
      wr_data    <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      overflow   <= 1'b0;
      word_count <= '0;
    end else begin
      state      <= state_d;
      in_ready   <= in_ready_d;
      wr_en      <= wr_en_d;
      wr_adrs    <= wr_adrs_d;
      wr_data    <= wr_data_d;
      busy       <= busy_d;
      done       <= done_d;
      overflow   <= overflow_d;
      word_count <= word_count_d;
    end
  end

  // Session data registers; only meaningful once IDLE/ACCEPT has loaded them.
  always_ff @(posedge clk) begin
    k    <= k_d;
    addr <= addr_d;
    word <= word_d;
    last <= last_d;
  end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Bench for instr_mem_loader: table of load sessions plus hand-built corner
// sequences; expected byte writes go through a scoreboard queue.
module tb_instr_mem_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [6:0]  base_adrs;
  logic        in_valid;
  logic        in_last;
  logic [31:0] in_instr;
  logic        in_ready;
  logic        wr_en;
  logic [6:0]  wr_adrs;
  logic [7:0]  wr_data;
  logic        busy;
  logic        done;
  logic        overflow;
  logic [5:0]  word_count;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [6:0] a;
    logic [7:0] d;
  } wr_t;
  wr_t sb[$];

  typedef struct {
    logic [6:0]  base;
    int          n;
    logic [31:0] w0;
    logic [31:0] w1;
    logic [31:0] w2;
    int          last_idx;
    int          exp_wc;
    bit          exp_ovf;
  } vec_t;
  vec_t vecs[5];

  instr_mem_loader #(.MEM_BYTES(128)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_adrs(base_adrs),
    .in_valid(in_valid), .in_last(in_last), .in_instr(in_instr),
    .in_ready(in_ready), .wr_en(wr_en), .wr_adrs(wr_adrs), .wr_data(wr_data),
    .busy(busy), .done(done), .overflow(overflow), .word_count(word_count)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  // Byte-write monitor: every strobe must match the next scoreboard entry.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && wr_en === 1'b1) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_write: got adrs=%h data=%h expected no write", wr_adrs, wr_data);
      end else begin
        wr_t e;
        e = sb.pop_front();
        chk("wr_adrs", {25'd0, wr_adrs}, {25'd0, e.a});
        chk("wr_data", {24'd0, wr_data}, {24'd0, e.d});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  // Called just after a rising edge; leaves the DUT in ACCEPT.
  task automatic do_start(input logic [6:0] b);
    start = 1'b1;
    base_adrs = b;
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_after_start", {31'd0, busy}, 32'd1);
    chk("ready_after_start", {31'd0, in_ready}, 32'd1);
    chk("wc_after_start", {26'd0, word_count}, 32'd0);
    chk("ovf_after_start", {31'd0, overflow}, 32'd0);
  endtask

  // Offer one word, expect 4 byte cycles, then ACCEPT or DONE.
  task automatic send_word(input logic [31:0] w, input bit lst, input int a,
                           input bit exp_done, input bit poke);
    bit ok = 0;
    in_valid = 1'b1;
    in_instr = w;
    in_last  = lst;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1; break; end
      @(posedge clk); #1;
    end
    if (!ok) begin
      chk("ready_timeout", 32'd0, 32'd1);
      in_valid = 1'b0;
      return;
    end
    for (int k = 0; k < 4; k++) sb.push_back('{7'(a + k), w[31 - 8*k -: 8]});
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("wr_en_byte", {31'd0, wr_en}, 32'd1);
      chk("ready_low_write", {31'd0, in_ready}, 32'd0);
      if (poke && k == 1) begin start = 1'b1; base_adrs = 7'h50; end
      if (poke && k == 2) start = 1'b0;
    end
    @(negedge clk);
    chk("done_after_word", {31'd0, done}, {31'd0, exp_done});
    chk("ready_after_word", {31'd0, in_ready}, {31'd0, !exp_done});
    chk("busy_after_word", {31'd0, busy}, 32'd1);
    @(posedge clk); #1;
    if (exp_done) begin
      chk("done_one_cycle", {31'd0, done}, 32'd0);
      chk("busy_idle", {31'd0, busy}, 32'd0);
    end
  endtask

  task automatic run_session(input vec_t v);
    logic [31:0] ws [3];
    int a;
    bit stop = 0;
    ws[0] = v.w0; ws[1] = v.w1; ws[2] = v.w2;
    a = {25'd0, v.base[6:2], 2'b00};
    do_start(v.base);
    for (int i = 0; i < v.n; i++) begin
      if (!stop) begin
        bit lastb = (i == v.last_idx);
        bit wrp = (((a + 4) % 128) == 0);
        send_word(ws[i], lastb, a, lastb || wrp, 1'b0);
        a = (a + 4) % 128;
        if (lastb || wrp) stop = 1;
      end else begin
        in_valid = 1'b1;
        in_instr = ws[i];
        in_last  = 1'b0;
        repeat (6) begin
          @(negedge clk);
          chk("refused_ready", {31'd0, in_ready}, 32'd0);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
      end
    end
    chk("session_wc", {26'd0, word_count}, 32'(v.exp_wc));
    chk("session_ovf", {31'd0, overflow}, {31'd0, v.exp_ovf});
    chk("session_sb_empty", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    vecs[0] = '{7'h00, 1, 32'h00400193, 32'h0, 32'h0, 0, 1, 1'b0};
    vecs[1] = '{7'h13, 2, 32'h00100213, 32'h00b76463, 32'h0, 1, 2, 1'b0};
    vecs[2] = '{7'h78, 3, 32'h11223344, 32'h55667788, 32'h99aabbcc, -1, 2, 1'b1};
    vecs[3] = '{7'h7C, 1, 32'hcafef00d, 32'h0, 32'h0, 0, 1, 1'b1};
    vecs[4] = '{7'h41, 3, 32'h01020304, 32'ha0b0c0d0, 32'hffeeddcc, 2, 3, 1'b0};

    rst_n = 1'b0; start = 1'b0; base_adrs = '0;
    in_valid = 1'b0; in_last = 1'b0; in_instr = '0;
    repeat (3) @(negedge clk);
    chk("rst_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_wr_en", {31'd0, wr_en}, 32'd0);
    chk("rst_wr_adrs", {25'd0, wr_adrs}, 32'd0);
    chk("rst_wr_data", {24'd0, wr_data}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_ovf", {31'd0, overflow}, 32'd0);
    chk("rst_wc", {26'd0, word_count}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_wait", {31'd0, busy}, 32'd0);

    for (int i = 0; i < 5; i++) run_session(vecs[i]);

    // Idle valid gap: ready stays up and nothing is written.
    do_start(7'h20);
    repeat (10) begin
      @(negedge clk);
      chk("gap_ready", {31'd0, in_ready}, 32'd1);
      chk("gap_wr_en", {31'd0, wr_en}, 32'd0);
    end
    @(posedge clk); #1;
    send_word(32'h12345678, 1'b1, 32'h20, 1'b1, 1'b0);
    chk("gap_wc", {26'd0, word_count}, 32'd1);

    // Start pulsed mid-write must not disturb the session.
    do_start(7'h08);
    send_word(32'hdeadbeef, 1'b0, 32'h08, 1'b0, 1'b1);
    send_word(32'h0badf00d, 1'b1, 32'h0C, 1'b1, 1'b0);
    chk("poke_wc", {26'd0, word_count}, 32'd2);
    chk("poke_ovf", {31'd0, overflow}, 32'd0);

    // Reset between bytes 1 and 2.
    do_start(7'h30);
    in_valid = 1'b1; in_instr = 32'hdeadbeef; in_last = 1'b0;
    @(negedge clk);
    chk("rstmid_ready", {31'd0, in_ready}, 32'd1);
    sb.push_back('{7'h30, 8'hde});
    sb.push_back('{7'h31, 8'had});
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rstmid_wr_en", {31'd0, wr_en}, 32'd0);
    chk("rstmid_busy", {31'd0, busy}, 32'd0);
    chk("rstmid_adrs", {25'd0, wr_adrs}, 32'd0);
    chk("rstmid_data", {24'd0, wr_data}, 32'd0);
    chk("rstmid_wc", {26'd0, word_count}, 32'd0);
    chk("rstmid_sb", 32'(sb.size()), 32'd0);
    repeat (3) begin
      @(negedge clk);
      chk("rstmid_hold_wr_en", {31'd0, wr_en}, 32'd0);
    end
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("rstmid_no_write", {31'd0, wr_en}, 32'd0);
      chk("rstmid_idle", {31'd0, busy}, 32'd0);
    end
    @(posedge clk); #1;
    run_session(vecs[0]);

    chk("final_sb_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instr_mem_loader.md
INSTR_MEM_LOADER -- requirements
Module: instr_mem_loader

Interface
REQ-001 SHALL have parameter MEM_BYTES, default 128, giving the size of the byte-wide instruction memory being written (32 words x 4 bytes).
REQ-002 SHALL have port clk  input  1  system clock, rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port start  input  1  single-cycle request to begin a load session.
REQ-005 SHALL have port base_adrs  input  7  starting byte address; bits [1:0] are ignored (treated as 0).
REQ-006 SHALL have port in_valid  input  1  an instruction word is offered.
REQ-007 SHALL have port in_last  input  1  the offered word is the final word of the session.
REQ-008 SHALL have port in_instr  input  32  the instruction word.
REQ-009 SHALL have port in_ready  output  1  the loader accepts a word this cycle.
REQ-010 SHALL have port wr_en  output  1  byte write strobe to instruction memory.
REQ-011 SHALL have port wr_adrs  output  7  byte address for the write.
REQ-012 SHALL have port wr_data  output  8  byte data for the write.
REQ-013 SHALL have port busy  output  1  a session is in progress.
REQ-014 SHALL have port done  output  1  single-cycle pulse at the end of a session.
REQ-015 SHALL have port overflow  output  1  sticky flag: the session ran past the top of memory.
REQ-016 SHALL have port word_count  output  6  number of words written in the current or last session (0..32).

Function
REQ-017 SHALL implement the FSM states IDLE, ACCEPT, WRITE and DONE, with all outputs registered.
REQ-018 In IDLE: in_ready=0 and wr_en=0; start=1 latches {base_adrs[6:2],2'b00} into the address counter, clears word_count and overflow, and moves to ACCEPT.
REQ-019 In ACCEPT: in_ready=1; when in_valid=1, in_instr and in_last are captured in the same cycle and the FSM moves to WRITE.
REQ-020 A word SHALL transfer only on the cycle where in_valid=1 and in_ready=1; in_ready SHALL be 0 during WRITE and DONE.
REQ-021 WRITE SHALL last exactly 4 cycles with byte index k=0..3 and wr_en=1, wr_adrs=addr+k, wr_data=word[31-8k -: 8] (big-endian: MSB at lowest address, so a memory read of {mem[a],mem[a+1],mem[a+2],mem[a+3]} returns the original word).
REQ-022 Latency: for a handshake at cycle N, the byte writes SHALL occur in cycles N+1..N+4, and in_ready SHALL return to 1 at N+5 when the session continues (5 cycles per word).
REQ-023 After byte 3: addr SHALL advance by 4 modulo MEM_BYTES and word_count SHALL increment; the next state is DONE if in_last=1 was captured, DONE with overflow set to 1 if addr wrapped to 0, and ACCEPT otherwise.
REQ-024 If in_last=1 and a wrap occur on the same word, overflow SHALL be set to 1 and the FSM SHALL go to DONE.
REQ-025 DONE SHALL assert done=1 for one cycle and then return to IDLE.
REQ-026 busy SHALL be 1 in ACCEPT, WRITE and DONE, and 0 in IDLE.
REQ-027 start SHALL be ignored whenever busy=1.
REQ-028 When wr_en=0, wr_adrs and wr_data SHALL hold their last values.
REQ-029 word_count and overflow SHALL hold their values in IDLE until the next accepted start.

Reset
REQ-030 rst_n=0 SHALL immediately force state=IDLE and in_ready=0, wr_en=0, wr_adrs=0, wr_data=0, busy=0, done=0, overflow=0, word_count=0, regardless of clk.
REQ-031 Reset asserted mid-WRITE SHALL abort the session with no further wr_en pulses; the bytes already written are left in memory.
REQ-032 After rst_n deasserts, the block SHALL wait in IDLE for start.

Verification
REQ-033 start, base_adrs=0, then one word 0x00400193 with in_last=1 -> writes 0x00@0, 0x40@1, 0x01@2, 0x93@3 in 4 consecutive cycles; done pulses; word_count=1; overflow=0.
REQ-034 base_adrs=0x13, then words 0x00100213 and 0x00b76463 (in_last on the second) -> writes begin at address 0x10; the second word lands at 0x14..0x17; word_count=2.
REQ-035 base_adrs=0x78 with three words and no in_last -> writes at 0x78 and 0x7C, then overflow=1 and done after word 2 with word_count=2; the third word is never accepted (in_ready stays 0).
REQ-036 in_valid held low for 10 cycles in ACCEPT -> in_ready stays 1 and wr_en stays 0; a later in_valid=1 for one cycle transfers the word normally.
REQ-037 start pulsed during WRITE -> ignored; the address sequence and word_count are unaffected.
REQ-038 rst_n driven low between bytes 1 and 2 of a word -> all outputs go to 0 immediately with no further writes; a following session works normally.
